// File: rtl/corner_collector.sv
// Buffers NMS corners into a first-word-fall-through FIFO with end-of-frame tagging,
// and keeps per-frame accepted/dropped corner counts plus a sticky overflow flag.
module corner_collector #(
  parameter int DEPTH = 64,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  input  logic                     corner_in,
  input  logic [9:0]               x_coord_in,
  input  logic [9:0]               y_coord_in,
  input  logic                     frame_start,
  input  logic                     frame_end,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [9:0]               m_x,
  output logic [9:0]               m_y,
  output logic                     m_eof,
  output logic                     m_null,
  output logic [CNT_W-1:0]         frame_corners,
  output logic [CNT_W-1:0]         frame_dropped,
  output logic                     frame_done,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]        LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]        LVL_RSV  = (AW+1)'(DEPTH - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

  logic [21:0]      mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [21:0]      wr_data;
  logic [21:0]      rd_word;
  logic             corner;
  logic             wr_req;
  logic             wr_ok;
  logic             rd_en;
  logic             acc_inc;
  logic             drop_inc;
  logic             lost;
  logic [CNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] acc_sum;
  logic [CNT_W-1:0] drop_sum;

  // Admission looks at the occupancy from the start of the cycle; the last slot
  // is held back so an end-of-frame marker always has somewhere to go.
  always_comb begin
    corner   = ce & corner_in;
    wr_req   = corner | frame_end;
    wr_ok    = 1'b0;
    if (frame_end)
      wr_ok = (level < LVL_FULL);
    else if (corner)
      wr_ok = (level < LVL_RSV);
    rd_en    = m_valid & m_ready;
    acc_inc  = corner & wr_ok;
    drop_inc = corner & ~wr_ok;
    lost     = wr_req & ~wr_ok;
    wr_data  = {frame_end, ~corner,
                corner ? x_coord_in : 10'd0,
                corner ? y_coord_in : 10'd0};
    acc_sum  = (acc_inc && acc_cnt != CNT_MAX) ? acc_cnt + 1'b1 : acc_cnt;
    drop_sum = (drop_inc && drop_cnt != CNT_MAX) ? drop_cnt + 1'b1 : drop_cnt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(wr_ok) - (AW+1)'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_comb begin
    rd_word = mem[rd_ptr];
    m_valid = (level != '0);
    m_eof   = m_valid & rd_word[21];
    m_null  = m_valid & rd_word[20];
    m_x     = m_valid ? rd_word[19:10] : 10'd0;
    m_y     = m_valid ? rd_word[9:0]   : 10'd0;
  end

  // frame_end closes the frame including its own corner; frame_start alone
  // restarts counting with whatever corner arrives alongside it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_cnt       <= '0;
      drop_cnt      <= '0;
      frame_corners <= '0;
      frame_dropped <= '0;
      frame_done    <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (frame_end) begin
        frame_corners <= acc_sum;
        frame_dropped <= drop_sum;
        acc_cnt       <= '0;
        drop_cnt      <= '0;
      end else if (frame_start) begin
        acc_cnt  <= CNT_W'(acc_inc);
        drop_cnt <= CNT_W'(drop_inc);
      end else begin
        acc_cnt  <= acc_sum;
        drop_cnt <= drop_sum;
      end
      if (frame_start)
        overflow <= lost & ~frame_end;
      else
        overflow <= overflow | lost;
    end
  end

endmodule

// File: tb/tb_corner_collector.sv
// Directed plus randomized checks of corner_collector against a queue-based frame model.
module tb_corner_collector;
  localparam int DEPTH   = 64;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic ce, corner_in, frame_start, frame_end, m_ready;
  logic [9:0] x_coord_in, y_coord_in;
  logic m_valid, m_eof, m_null, frame_done, overflow;
  logic [9:0] m_x, m_y;
  logic [CNT_W-1:0] frame_corners, frame_dropped;
  logic [$clog2(DEPTH):0] level;

  always #5 clk = ~clk;

  corner_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ce(ce), .corner_in(corner_in),
    .x_coord_in(x_coord_in), .y_coord_in(y_coord_in),
    .frame_start(frame_start), .frame_end(frame_end),
    .m_valid(m_valid), .m_ready(m_ready), .m_x(m_x), .m_y(m_y),
    .m_eof(m_eof), .m_null(m_null), .frame_corners(frame_corners),
    .frame_dropped(frame_dropped), .frame_done(frame_done),
    .overflow(overflow), .level(level)
  );

  int total = 0;
  int bad   = 0;

  // reference model: queue of {eof, null, x, y} entries and frame bookkeeping
  logic [21:0] q[$];
  int  acc, drop, exp_fc, exp_fd;
  bit  exp_done, exp_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    acc = 0; drop = 0; exp_fc = 0; exp_fd = 0;
    exp_done = 0; exp_ovf = 0;
  endfunction

  task automatic model_step();
    bit c, ok, rd, lost;
    int lvl;
    c    = ce & corner_in;
    lvl  = q.size();
    rd   = (lvl > 0) && m_ready;
    ok   = frame_end ? (lvl < DEPTH) : (c && (lvl < DEPTH - 1));
    lost = (c || frame_end) && !ok;
    if (rd) void'(q.pop_front());
    if (ok) q.push_back({frame_end, ~c, c ? x_coord_in : 10'd0, c ? y_coord_in : 10'd0});
    if (frame_start && !frame_end) begin
      acc = 0; drop = 0; exp_ovf = 0;
    end
    if (c && ok  && acc  < CNT_MAX) acc++;
    if (c && !ok && drop < CNT_MAX) drop++;
    if (lost) exp_ovf = 1;
    exp_done = frame_end;
    if (frame_end) begin
      exp_fc = acc; exp_fd = drop; acc = 0; drop = 0;
      if (frame_start) exp_ovf = 0;
    end
  endtask

  task automatic check_all();
    logic [21:0] e;
    e = (q.size() > 0) ? q[0] : 22'd0;
    chk("m_valid", m_valid, q.size() > 0);
    chk("m_x", m_x, e[19:10]);
    chk("m_y", m_y, e[9:0]);
    chk("m_eof", m_eof, e[21]);
    chk("m_null", m_null, e[20]);
    chk("level", level, q.size());
    chk("overflow", overflow, exp_ovf);
    chk("frame_done", frame_done, exp_done);
    chk("frame_corners", frame_corners, exp_fc);
    chk("frame_dropped", frame_dropped, exp_fd);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input bit c, input int x, input int y, input bit e,
                       input bit fs, input bit fe, input bit rdy);
    corner_in   = c;
    x_coord_in  = 10'(x);
    y_coord_in  = 10'(y);
    ce          = e;
    frame_start = fs;
    frame_end   = fe;
    m_ready     = rdy;
    cycle();
  endtask

  initial begin
    rst = 1'b0;
    ce = 0; corner_in = 0; frame_start = 0; frame_end = 0; m_ready = 0;
    x_coord_in = 0; y_coord_in = 0;
    model_reset();
    @(negedge clk);
    check_all();
    rst = 1'b1;
    drive(0, 0, 0, 1, 0, 0, 0);

    // single corner, consumer always ready
    drive(1, 100, 37, 1, 0, 0, 1);
    chk("single_valid", m_valid, 1);
    chk("single_x", m_x, 100);
    chk("single_y", m_y, 37);
    chk("single_eof", m_eof, 0);
    drive(0, 0, 0, 1, 0, 0, 1);
    chk("single_level0", level, 0);

    // frame close: 5 corners then a bare frame_end
    drive(0, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) drive(1, 10 + i, 20 + i, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 1, 0);
    chk("close_done", frame_done, 1);
    chk("close_corners", frame_corners, 5);
    chk("close_dropped", frame_dropped, 0);
    chk("close_level", level, 6);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin
        chk("close_last_eof", m_eof, 1);
        chk("close_last_null", m_null, 1);
      end
      drive(0, 0, 0, 1, 0, 0, 1);
    end
    chk("close_done_once", frame_done, 0);

    // corner coincident with frame_end
    drive(1, 1, 2, 1, 0, 0, 0);
    drive(1, 3, 4, 1, 0, 0, 0);
    drive(1, 5, 6, 1, 0, 1, 0);
    chk("coin_corners", frame_corners, 3);
    drive(0, 0, 0, 1, 0, 0, 1);
    drive(0, 0, 0, 1, 0, 0, 1);
    chk("coin_eof", m_eof, 1);
    chk("coin_null", m_null, 0);
    chk("coin_x", m_x, 5);
    drive(0, 0, 0, 1, 0, 0, 1);

    // overflow: 70 corners into a stalled FIFO, then frame_end
    drive(0, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 70; i++) drive(1, i, 1023 - i, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 1, 0);
    chk("ovf_level", level, 64);
    chk("ovf_flag", overflow, 1);
    chk("ovf_corners", frame_corners, 63);
    chk("ovf_dropped", frame_dropped, 7);
    for (int i = 0; i < 64; i++) begin
      if (i == 63) begin
        chk("ovf_last_eof", m_eof, 1);
        chk("ovf_last_null", m_null, 1);
      end
      drive(0, 0, 0, 1, 0, 0, 1);
    end
    chk("ovf_drained", level, 0);

    // ce gating
    drive(0, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 10; i++) drive(1, 7, 7, 0, 0, 0, 0);
    chk("ce_level", level, 0);
    drive(1, 7, 7, 0, 0, 1, 0);
    chk("ce_marker_level", level, 1);
    chk("ce_marker_null", m_null, 1);
    drive(0, 0, 0, 1, 0, 0, 1);

    // asynchronous reset mid-frame
    for (int i = 0; i < 10; i++) drive(1, 200 + i, i, 1, 0, 0, 0);
    chk("pre_rst_level", level, 10);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("rst_valid", m_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", overflow, 0);
    @(negedge clk);
    check_all();
    rst = 1'b1;
    drive(0, 0, 0, 1, 0, 0, 0);

    // randomized traffic with alternating back-pressure regimes
    for (int i = 0; i < 3000; i++) begin
      bit rdy_hi;
      rdy_hi = ((i / 200) % 2) == 0;
      drive($urandom_range(1, 0) == 1,
            int'($urandom_range(1023, 0)), int'($urandom_range(1023, 0)),
            $urandom_range(9, 0) != 0,
            $urandom_range(59, 0) == 0,
            $urandom_range(39, 0) == 0,
            rdy_hi ? ($urandom_range(3, 0) != 0) : ($urandom_range(7, 0) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/corner_collector.md
Name: corner_collector

Overview:
- Sits directly downstream of the 3x3 non-maximum-suppression stage.
- Captures each surviving corner (corner flag plus 10-bit x/y coordinates) into an on-chip FIFO.
- Tags the end of each frame in the FIFO stream and presents corners to the host/DMA side over a valid/ready stream.
- Keeps per-frame accepted and dropped corner counts and a sticky overflow flag, so bursts of corners in dense image regions never stall the pixel pipeline.

Parameters:
- DEPTH, 64, FIFO entries; power of two, >= 4.
- CNT_W, 16, width of the per-frame counters; saturating.

Ports:
- clk  input  1  pixel clock.
- rst  input  1  reset, asynchronous, active-low.
- ce  input  1  pipeline enable; qualifies corner_in and the coordinates only.
- corner_in  input  1  NMS corner_out.
- x_coord_in  input  10  NMS x_coord_out.
- y_coord_in  input  10  NMS y_coord_out.
- frame_start  input  1  one-cycle pulse, start of frame; not gated by ce.
- frame_end  input  1  one-cycle pulse, last NMS output of frame; not gated by ce.
- m_valid  output  1  output entry available.
- m_ready  input  1  consumer accepts entry.
- m_x  output  10  corner x.
- m_y  output  10  corner y.
- m_eof  output  1  entry closes a frame.
- m_null  output  1  entry carries no corner (pure end-of-frame marker).
- frame_corners  output  CNT_W  accepted-corner total of the last closed frame.
- frame_dropped  output  CNT_W  dropped-corner total of the last closed frame.
- frame_done  output  1  one-cycle pulse when frame_corners/frame_dropped update.
- overflow  output  1  sticky: a corner or marker was dropped this frame.
- level  output  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO empty, m_valid=0, m_x/m_y/m_eof/m_null=0.
  - Counters, frame_corners, frame_dropped and level = 0.
  - frame_done=0, overflow=0.
  - Reset mid-frame discards all FIFO contents.
- Entry format: {eof, null, x, y}, 22 bits. One write per cycle maximum.
- Write event, each cycle:
  - corner = ce & corner_in.
  - corner & frame_end: write {1,0,x,y}.
  - corner only: write {0,0,x,y}.
  - frame_end only: write {1,1,0,0}.
  - Otherwise no write.
- Admission uses the level at the start of the cycle (a same-cycle read does not free space):
  - Corner entry without eof: accepted only if level < DEPTH-1. The last slot is reserved for markers.
  - Any eof entry: accepted if level < DEPTH.
  - Rejected corner: dropped counter +1, overflow set.
  - Rejected eof-with-corner: the corner is counted as dropped, overflow set, and frame close still happens.
- Counters:
  - Accepted counter +1 per accepted corner.
  - Both counters saturate at 2^CNT_W-1.
- frame_end:
  - Next cycle, frame_corners and frame_dropped load the counter values, including the corner of the same cycle.
  - frame_done pulses high for that one cycle.
  - Counters clear to 0 in the same update.
- frame_start clears both counters and overflow.
  - If a corner arrives in the same cycle, the counter ends at 1 (or dropped ends at 1).
  - frame_start and frame_end in the same cycle: frame_end processing first, then clear; overflow ends 0.
  - frame_start does not flush the FIFO.
- Read side, first-word-fall-through:
  - An entry written to an empty FIFO appears on m_* with m_valid=1 on the next cycle (1-cycle latency).
  - Transfer occurs on m_valid & m_ready; the next entry is presented the following cycle, or m_valid drops.
  - m_* are held stable while m_valid & !m_ready.
  - Simultaneous read and write at level=DEPTH-1: corner rejected, read proceeds, level ends at DEPTH-2.
  - At level=0 with a write: no read occurs that cycle.
- level updates one cycle after each write/read. Pointers wrap modulo DEPTH.
- ce=0 blocks corner capture only; the read side and frame pulses keep operating.

Test Plan:
- Single corner: rst released, corner_in=1, x=100, y=37, ce=1, m_ready=1 -> next cycle m_valid=1, m_x=100, m_y=37, m_eof=0, m_null=0; level returns to 0 after the transfer.
- Frame close: 5 corners, then frame_end alone -> 6 entries out, the last being {eof=1, null=1}; frame_done pulses once; frame_corners=5, frame_dropped=0.
- Coincident end: 3 corners, the third with frame_end -> third entry has m_eof=1, m_null=0; frame_corners=3.
- Overflow with DEPTH=64, m_ready=0:
  - 70 corners, then frame_end -> level=64 (63 corners + marker); overflow=1; frame_corners=63, frame_dropped=7.
  - Drain all -> last entry eof=1, null=1.
- ce gating: corner_in=1 held with ce=0 for 10 cycles -> no writes, level=0; frame_end with ce=0 still writes a marker.
- Mid-frame async reset: 10 entries queued, rst pulsed low between clock edges -> m_valid=0, level=0 and overflow=0 immediately.
